// File: rtl/call_stack_pkg.sv
// call_stack_pkg: shared PC width, return-address step and stack depth for the control path.
package call_stack_pkg;
  localparam int ADDR_W = 10;
  localparam int DEPTH = 16;
  localparam int PC_STEP = 2;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/call_stack_if.sv
// call_stack_if: decoder-side strobes in, return address and stack status out.
interface call_stack_if import call_stack_pkg::*; #(
  parameter int ADDR_W = call_stack_pkg::ADDR_W,
  parameter int DEPTH = call_stack_pkg::DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic en;
  logic flush;
  logic push;
  logic pop;
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] ret_addr;
  logic ret_valid;
  logic [CW-1:0] count;
  logic empty;
  logic full;
  logic overflow;
  logic underflow;
  modport master (
    output en, flush, push, pop, pc_in,
    input ret_addr, ret_valid, count, empty, full, overflow, underflow
  );
  modport slave (
    input en, flush, push, pop, pc_in,
    output ret_addr, ret_valid, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack_mem.sv
// call_stack_mem: return-address array, one synchronous write port and one async read port.
module call_stack_mem import call_stack_pkg::*; #(
  parameter int ADDR_W = call_stack_pkg::ADDR_W,
  parameter int DEPTH = call_stack_pkg::DEPTH
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_W-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0] rdata
);
  logic [ADDR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack.sv
// call_stack: circular return-address stack for CALL/RET; pop result is combinational into the PC.
module call_stack import call_stack_pkg::*; #(
  parameter int ADDR_W = call_stack_pkg::ADDR_W,
  parameter int DEPTH = call_stack_pkg::DEPTH,
  parameter int PC_STEP = call_stack_pkg::PC_STEP
) (
  input  logic clk,
  input  logic rst,
  call_stack_if.slave s
);
  localparam int SW = $clog2(DEPTH);
  localparam int CW = SW + 1;
  logic [SW-1:0] sp, top_idx, wr_idx;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] rd_data, ra;
  logic empty, full, live_pop, do_push, do_pop, we, ov, un;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign top_idx = sp - SW'(1);
  assign live_pop = s.pop & ~empty;
  // push+pop on a non-empty stack is a replace; on an empty stack it degrades to a push
  assign do_push = s.push & ~live_pop;
  assign do_pop = live_pop & ~s.push;
  assign ra = s.pc_in + ADDR_W'(PC_STEP);
  assign we = s.en & ~s.flush & s.push;
  assign wr_idx = live_pop ? top_idx : sp;
  call_stack_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(wr_idx),
    .wdata(ra),
    .raddr(top_idx),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      count <= '0;
      ov <= 1'b0;
      un <= 1'b0;
    end else if (s.en) begin
      if (s.flush) begin
        sp <= '0;
        count <= '0;
        ov <= 1'b0;
        un <= 1'b0;
      end else begin
        sp <= do_push ? sp + SW'(1) : do_pop ? top_idx : sp;
        count <= (do_push & ~full) ? count + CW'(1) : do_pop ? count - CW'(1) : count;
        ov <= ov | (do_push & full);
        un <= un | (s.pop & empty);
      end
    end
  end
  assign s.ret_addr = empty ? '0 : rd_data;
  assign s.ret_valid = s.en & live_pop;
  assign s.count = count;
  assign s.empty = empty;
  assign s.full = full;
  assign s.overflow = ov;
  assign s.underflow = un;
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Hardware return-address stack: the write/read partner of program_counter for CALL/RET.
- CALL: pushes the return address (current PC + step).
- RET: pops the top entry onto ret_addr, which drives program_counter.din with jmp asserted on the same edge.
- Sits in the control path beside program_counter; is fed by decoder call/ret strobes.

Parameters:
- ADDR_W, 10, width of PC and of stored return addresses.
- DEPTH, 16, number of entries; must be a power of two, >= 2.
- PC_STEP, 2, value added to pc_in to form the return address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global stall; when 0, all state holds and push/pop are ignored.
- flush  input  1  synchronous clear (qualified by en); same effect as rst.
- push  input  1  CALL strobe; one push per cycle when high.
- pop  input  1  RET strobe; one pop per cycle when high.
- pc_in  input  ADDR_W  current PC (program_counter.dout).
- ret_addr  output  ADDR_W  combinational top-of-stack; 0 when empty.
- ret_valid  output  1  combinational, = pop & en & !empty; drives program_counter.jmp.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; push while full occurred.
- underflow  output  1  sticky; pop while empty occurred.

Behaviour:
- Storage:
  - Circular array of DEPTH entries.
  - Write pointer sp of $clog2(DEPTH) bits; top = mem[sp-1] (mod DEPTH).
  - count is tracked separately, saturating at DEPTH.
- Reset: rst (async) or en&flush (sync) sets sp=0, count=0, overflow=0, underflow=0. Array contents are not cleared. ret_addr=0, ret_valid=0, empty=1, full=0.
- Return address: pc_in + PC_STEP, truncated to ADDR_W (wraps mod 2^ADDR_W; e.g. 1022+2 stores 0).
- en=0: no state change; ret_valid=0; ret_addr still shows top.
- push only (en=1):
  - mem[sp] <= ret address; sp <= sp+1.
  - count <= count+1 if not full.
  - If full: count stays DEPTH, the oldest entry is silently overwritten (wrap-around), overflow <= 1.
- pop only (en=1):
  - Not empty: sp <= sp-1, count <= count-1; ret_addr already valid this cycle (zero latency into the PC).
  - Empty: no pointer/count change, ret_addr=0, ret_valid=0, underflow <= 1.
- push & pop same cycle (en=1):
  - Not empty: top entry replaced (mem[sp-1] <= ret address); sp/count unchanged; ret_addr/ret_valid reflect the OLD top this cycle.
  - Empty: treated as a push (count 0->1), underflow <= 1, ret_valid=0.
- flush has priority over push/pop in the same cycle.
- Sticky flags clear only on rst/flush.
- Latency: push visible on ret_addr the cycle after the edge; pop result combinational in the pop cycle.

Decomposition:
- batpu_pkg: ADDR_W constant, typedef addr_t = logic [ADDR_W-1:0], PC_STEP constant, shared with program_counter.
- Optional sub-module call_stack_mem: DEPTH x ADDR_W array, one write port, one async read port (read index = sp-1). Pointer/count/flag logic stays in call_stack.

Test Plan:
- Reset mid-operation: push 3 entries, assert rst asynchronously between edges -> count=0, empty=1, ret_addr=0, flags=0 immediately, without waiting for a clock edge.
- LIFO order: pc_in=0x010,0x020,0x030 with push on 3 cycles, then pop x3 -> ret_addr=0x032,0x022,0x012 with ret_valid=1 each cycle; count 3->0; empty=1 after.
- Overflow: 17 pushes with pc_in=0..32 step 2 -> full=1 after 16th, overflow=1 after 17th, count=16; 16 pops return 34 down to 4 (value 2 lost).
- Underflow and wrap: pop when empty -> ret_valid=0, ret_addr=0, underflow=1; push pc_in=0x3FE -> top = 0x000.
- Simultaneous push+pop: stack [0x0A], pc_in=0x100 -> ret_addr=0x0A that cycle, next cycle top=0x102, count=1.
- Stall and flush: en=0 with push=1 -> no change; en=1, flush=1, push=1 -> count=0, overflow/underflow cleared.
